// File: rtl/acl_spi_sequencer_pkg.sv
// Shared types and constants for the ADXL362 SPI sequencer.
package acl_spi_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE,
    ST_ABORT
  } state_e;

  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] CMD_WRITE      = 8'h0A;

  localparam logic [7:0] REG_XDATA_L    = 8'h0E;
  localparam logic [7:0] REG_FILTER_CTL = 8'h2C;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;

endpackage

// File: rtl/acl_poll_timer.sv
// Free-running wrap counter 0..POLL_CYCLES-1; expire_o pulses for one cycle after each wrap.
module acl_poll_timer #(
  parameter int POLL_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic expire_o
);
  localparam int CW = $clog2(POLL_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;
  logic          expire_q;

  assign wrap  = (cnt_q == CW'(POLL_CYCLES - 1));
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= wrap;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/acl_spi_sequencer.sv
// ADXL362 transaction sequencer: periodic burst reads assembled into one sample word, plus register writes.
// Every output is a register loaded from the next-state decode, so outputs line up with the FSM state.
module acl_spi_sequencer
  import acl_spi_sequencer_pkg::*;
#(
  parameter int         POLL_CYCLES = 1000,
  parameter int         BURST_LEN   = 6,
  parameter logic [7:0] START_ADDR  = REG_XDATA_L,
  parameter int         ACT_TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   wr_req_i,
  input  logic [7:0]             wr_addr_i,
  input  logic [7:0]             wr_data_i,
  output logic                   wr_ack_o,
  output logic                   start_o,
  output logic [7:0]             tx_data_o,
  input  logic                   active_i,
  input  logic [7:0]             rx_data_i,
  output logic                   cs_n_o,
  output logic [8*BURST_LEN-1:0] sample_o,
  output logic                   sample_valid_o,
  output logic                   busy_o,
  output logic                   error_o
);
  localparam int         SW   = 8 * BURST_LEN;
  localparam int         TO_W = $clog2(ACT_TIMEOUT + 1);
  localparam logic [4:0] N_RD = 5'(BURST_LEN + 2);

  state_e          state_q, state_d;
  logic [4:0]      k_q, k_d, n_bytes;
  logic [TO_W-1:0] to_q, to_d;
  logic            rd_q, rd_d;
  logic [7:0]      addr_q, addr_d, data_q, data_d;
  logic [SW-1:0]   shadow_q, shadow_d, sample_q;
  logic [7:0]      tx_q, tx_d;
  logic            poll_pend_q, poll_exp, take_poll;
  logic            start_q, cs_n_q, busy_q, sv_q, ack_q, err_q;

  acl_poll_timer #(.POLL_CYCLES(POLL_CYCLES)) u_poll_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .expire_o (poll_exp)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    to_d      = to_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    shadow_d  = shadow_q;
    take_poll = 1'b0;
    n_bytes   = rd_q ? N_RD : 5'd3;
    case (state_q)
      ST_IDLE: begin
        k_d = '0;
        // A held write request always wins over a pending poll.
        if (wr_req_i) begin
          state_d = ST_SETUP;
          rd_d    = 1'b0;
          addr_d  = wr_addr_i;
          data_d  = wr_data_i;
        end else if (poll_pend_q && enable_i) begin
          state_d   = ST_SETUP;
          rd_d      = 1'b1;
          take_poll = 1'b1;
        end
      end
      ST_SETUP: state_d = ST_SEND;
      ST_SEND: begin
        state_d = ST_WAIT_HI;
        to_d    = '0;
      end
      ST_WAIT_HI: begin
        if (active_i) begin
          state_d = ST_WAIT_LO;
        end else if (to_q == TO_W'(ACT_TIMEOUT - 1)) begin
          state_d = ST_ABORT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!active_i) begin
          for (int i = 0; i < BURST_LEN; i++) begin
            if (rd_q && k_q == 5'(i + 2)) shadow_d[8*i +: 8] = rx_data_i;
          end
          k_d     = k_q + 5'd1;
          state_d = (k_d < n_bytes) ? ST_SEND : ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The byte is loaded on entry to SEND and held until the next SEND.
  always_comb begin
    tx_d = tx_q;
    if (state_d == ST_SEND) begin
      if (k_d == 5'd0)      tx_d = rd_d ? CMD_READ : CMD_WRITE;
      else if (k_d == 5'd1) tx_d = rd_d ? START_ADDR : addr_d;
      else                  tx_d = rd_d ? 8'h00 : data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      to_q        <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      shadow_q    <= '0;
      sample_q    <= '0;
      tx_q        <= '0;
      poll_pend_q <= 1'b0;
      start_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      sv_q        <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      to_q        <= to_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      shadow_q    <= shadow_d;
      tx_q        <= tx_d;
      poll_pend_q <= poll_exp | (poll_pend_q & ~take_poll);
      start_q     <= (state_d == ST_SEND);
      cs_n_q      <= !(state_d inside {ST_SETUP, ST_SEND, ST_WAIT_HI, ST_WAIT_LO});
      busy_q      <= (state_d != ST_IDLE);
      sv_q        <= (state_d == ST_DONE) && rd_d;
      ack_q       <= (state_d == ST_DONE) && !rd_d;
      err_q       <= err_q | (state_d == ST_ABORT);
      if (state_d == ST_DONE && rd_d) sample_q <= shadow_d;
    end
  end

  assign start_o        = start_q;
  assign tx_data_o      = tx_q;
  assign cs_n_o         = cs_n_q;
  assign busy_o         = busy_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sv_q;
  assign wr_ack_o       = ack_q;
  assign error_o        = err_q;

endmodule

// File: doc/acl_spi_sequencer.md
# acl_spi_sequencer

Parametrised transaction sequencer for the PmodACL2 (ADXL362) SPI path. It sits between the byte-level SPI master (start/active/tx_data/rx_data) and the sample consumer. It periodically issues a burst register read of BURST_LEN consecutive registers and assembles the returned bytes into one wide sample word. On request it also performs single-register configuration writes.

## Interface
- POLL_CYCLES, 1000: clk cycles between poll-timer expiries; must be ≥ 2.
- BURST_LEN, 6: bytes read per burst, 1..16.
- START_ADDR, 8'h0E: first register address of the burst (XDATA_L).
- ACT_TIMEOUT, 64: max cycles to wait for `active` to rise after `start`.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  enables periodic polling; writes are allowed regardless.
- wr_req  in  1  configuration write request; held until wr_ack.
- wr_addr  in  8  register address for the write.
- wr_data  in  8  register value for the write.
- wr_ack  out  1  one-cycle pulse when the write transaction completes.
- start  out  1  one-cycle pulse to the SPI master: send tx_data.
- tx_data  out  8  byte presented to the SPI master.
- active  in  1  SPI master busy shifting a byte.
- rx_data  in  8  byte received by the SPI master; valid when `active` falls.
- cs_n  out  1  chip select, low for the whole transaction.
- sample  out  8*BURST_LEN  last burst; byte i (register START_ADDR+i) at bits [8i+7:8i].
- sample_valid  out  1  one-cycle pulse when `sample` updates.
- busy  out  1  transaction in progress.
- error  out  1  sticky flag for an `active` timeout; cleared by rst only.

## Operation
- Poll timer counts 0..POLL_CYCLES-1 and wraps. Expiry sets `poll_pend`. It keeps running while busy. Expiries while `poll_pend` is set are merged.
- Read transaction bytes: 0x0B, START_ADDR, then BURST_LEN × 0x00. Total N = BURST_LEN+2.
- Write transaction bytes: 0x0A, wr_addr, wr_data. N = 3. wr_addr and wr_data are latched at transaction begin.
- Arbitration in IDLE: a pending write has priority over `poll_pend`. A poll is taken only when `enable`=1. Taking a poll clears `poll_pend`.
- FSM states and transitions:
  - IDLE → SETUP on a selected transaction: cs_n falls, byte index k=0.
  - SETUP → SEND.
  - SEND: start=1 for one cycle; → WAIT_HI.
  - WAIT_HI: on active=1 → WAIT_LO. If ACT_TIMEOUT cycles elapse → ABORT.
  - WAIT_LO: on active=0, capture rx_data when k ≥ 2 on a read, then k++. → SEND if k<N, else → DONE.
  - DONE: cs_n rises; sample_valid pulses (read) or wr_ack pulses (write); → IDLE.
  - ABORT: cs_n rises, error=1, no sample_valid or wr_ack. A pending write stays pending. → IDLE.
- `sample` updates atomically from a shadow register in DONE only. A partial burst never becomes visible.
- tx_data is stable from SEND until active falls.
- Reset values: start=0, tx_data=0, cs_n=1, busy=0, sample=0, sample_valid=0, wr_ack=0, error=0, poll timer=0, poll_pend=0. Reset mid-transaction returns to IDLE in the next cycle with cs_n=1.

## Timing
- All outputs are registered.
- busy=1 from SETUP through DONE inclusive.
- The first start is issued 2 cycles after transaction selection: IDLE→SETUP→SEND.
- Inter-byte gap: start is asserted 1 cycle after active falls.
- Minimum cs_n high time between transactions: 2 cycles (DONE, IDLE).
- enable deasserted mid-burst: the burst completes normally.
- wr_req raised during a read: the write is served right after the read's DONE.

## Structure
- Shared package: FSM state encoding, command bytes CMD_READ=8'h0B and CMD_WRITE=8'h0A, ADXL362 register addresses.
- Sub-module `acl_poll_timer`: parametrised wrap counter producing a one-cycle expiry pulse.

## Test plan
- POLL_CYCLES=1000, enable=1, model returns 0x11..0x16 → tx sequence 0B,0E,00×6; sample=48'h161514131211; sample_valid at first DONE; next cs_n fall about 1000 cycles after the previous one.
- wr_req with addr 0x2D, data 0x02, enable=0 → tx 0A,2D,02; one wr_ack pulse; sample_valid never asserted.
- wr_req raised mid-burst → burst completes with correct sample, then write bytes follow; cs_n high for ≥2 cycles between transactions.
- Model never raises active → after 64 cycles cs_n=1, error=1, no sample_valid; sample keeps its old value.
- rst asserted while in WAIT_LO of byte 4 → next cycle cs_n=1, busy=0, start=0, sample unchanged (0 after reset).
- BURST_LEN=1, active stretched to 100 cycles → exactly 3 start pulses, each 1 cycle after active falls.
